// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag indices and overflow helpers for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_RED    = 3'b011,
    OP_SLL    = 3'b100,
    OP_SRA    = 3'b101,
    OP_ROR    = 3'b110,
    OP_PADDSB = 3'b111
  } alu_op_t;

  // Flag register layout {Z,V,N}
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [FLAG_W-1:0] FMASK_NONE = 3'b000;
  localparam logic [FLAG_W-1:0] FMASK_Z    = 3'b100;
  localparam logic [FLAG_W-1:0] FMASK_ALL  = 3'b111;

  // Signed overflow of a+b from sign bits: {positive overflow, negative overflow}
  function automatic logic [1:0] add_ovf(input logic sa, input logic sb, input logic sr);
    return {~sa & ~sb & sr, sa & sb & ~sr};
  endfunction

  // Signed overflow of a-b from sign bits: {positive overflow, negative overflow}
  function automatic logic [1:0] sub_ovf(input logic sa, input logic sb, input logic sr);
    return {~sa & sb & sr, sa & ~sb & ~sr};
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU core: result, pre-saturation overflow and flag write-mask per opcode.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  alu_op_t           op,
  output logic [WIDTH-1:0]  result_c,
  output logic              err_c,
  output logic [FLAG_W-1:0] fmask_c
);

  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned NBYTE = WIDTH / 8;
  localparam int unsigned NLANE = WIDTH / LANE;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [1:0]       add_o;
  logic [1:0]       sub_o;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] red_sum;
  logic [WIDTH-1:0] lane_sum;
  logic [LANE-1:0]  lsum;
  logic [1:0]       lovf;

  assign sum   = a + b;
  assign diff  = a - b;
  assign add_o = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
  assign sub_o = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
  assign shamt = b[SHW-1:0];
  assign rot   = WIDTH'({a, a} >> shamt);

  // Sign-extended sum of every byte of both operands
  always_comb begin
    red_sum = '0;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      red_sum = red_sum + WIDTH'($signed(a[i*8 +: 8])) + WIDTH'($signed(b[i*8 +: 8]));
    end
  end

  // Independent saturating add per lane, no carry across lane boundaries
  always_comb begin
    lane_sum = '0;
    lsum     = '0;
    lovf     = '0;
    for (int unsigned l = 0; l < NLANE; l++) begin
      lsum = a[l*LANE +: LANE] + b[l*LANE +: LANE];
      lovf = add_ovf(a[l*LANE+LANE-1], b[l*LANE+LANE-1], lsum[LANE-1]);
      lane_sum[l*LANE +: LANE] = lovf[1] ? LMAX : (lovf[0] ? LMIN : lsum);
    end
  end

  // Opcode select
  always_comb begin
    result_c = '0;
    err_c    = 1'b0;
    fmask_c  = FMASK_NONE;
    unique case (op)
      OP_ADD: begin
        result_c = add_o[1] ? SMAX : (add_o[0] ? SMIN : sum);
        err_c    = |add_o;
        fmask_c  = FMASK_ALL;
      end
      OP_SUB: begin
        result_c = sub_o[1] ? SMAX : (sub_o[0] ? SMIN : diff);
        err_c    = |sub_o;
        fmask_c  = FMASK_ALL;
      end
      OP_XOR: begin
        result_c = a ^ b;
        fmask_c  = FMASK_Z;
      end
      OP_RED: begin
        result_c = red_sum;
      end
      OP_SLL: begin
        result_c = a << shamt;
        fmask_c  = FMASK_Z;
      end
      OP_SRA: begin
        result_c = WIDTH'($signed(a) >>> shamt);
        fmask_c  = FMASK_Z;
      end
      OP_ROR: begin
        result_c = rot;
        fmask_c  = FMASK_Z;
      end
      OP_PADDSB: begin
        result_c = lane_sum;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, flag register and flush.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_err,
  output logic [FLAG_W-1:0] flags
);

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  alu_op_t           s1_op;
  logic              s2_load;
  logic              in_fire;
  logic [WIDTH-1:0]  ex_result;
  logic              ex_err;
  logic [FLAG_W-1:0] ex_fmask;
  logic [FLAG_W-1:0] ex_flags;

  // A flushing cycle neither advances S1 into S2 nor accepts new input
  assign s2_load  = s1_valid & ~flush & (~out_valid | out_ready);
  assign in_ready = ~rst & ~flush & (~s1_valid | s2_load);
  assign in_fire  = in_valid & in_ready;

  alu_exec #(.WIDTH(WIDTH), .LANE(LANE)) u_exec (
    .a        (s1_a),
    .b        (s1_b),
    .op       (s1_op),
    .result_c (ex_result),
    .err_c    (ex_err),
    .fmask_c  (ex_fmask)
  );

  // Candidate flag values from the stage-2 result
  always_comb begin
    ex_flags         = '0;
    ex_flags[FLAG_Z] = (ex_result == '0);
    ex_flags[FLAG_V] = ex_err;
    ex_flags[FLAG_N] = ex_result[WIDTH-1];
  end

  // Stage 1: operand/opcode capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= alu_op_t'(in_op);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result/err registers and masked flag update
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
      flags      <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      out_result <= ex_result;
      out_err    <= ex_err;
      flags      <= (flags & ~ex_fmask) | (ex_flags & ex_fmask);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes modelled responses, monitor pops on output transfer.
module tb_alu_pipe;

  localparam int unsigned W = 16;
  localparam int unsigned L = 4;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, RED = 3'd3;
  localparam logic [2:0] SLL = 3'd4, SRA = 3'd5, ROR = 3'd6, PADDSB = 3'd7;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
    logic [2:0]   fl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [W-1:0] in_a, in_b, out_result;
  logic [2:0]   in_op, flags;

  exp_t       q[$];
  exp_t       mon_e;
  logic [2:0] mflags;
  logic [2:0] f_keep;
  logic       stall_req, bp_rand;
  int         tests = 0;
  int         fails = 0;
  int         last_wait;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .LANE(L)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .flags(flags)
  );

  function automatic int sval(input logic [31:0] v, input int bits);
    int u;
    u = int'(v & ((32'd1 << bits) - 1));
    return (u >= (1 << (bits - 1))) ? u - (1 << bits) : u;
  endfunction

  // Reference model: plain integer arithmetic from the opcode rules
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2:0] fin);
    exp_t e;
    int   sa, sb, s, sh, la, lb;
    e.res = '0; e.err = 1'b0; e.fl = fin;
    sa = sval(32'(a), 16);
    sb = sval(32'(b), 16);
    sh = int'(b[3:0]);
    case (op)
      ADD, SUB: begin
        s = (op == ADD) ? sa + sb : sa - sb;
        if (s > 32767) begin e.res = 16'h7FFF; e.err = 1'b1; end
        else if (s < -32768) begin e.res = 16'h8000; e.err = 1'b1; end
        else e.res = 16'(s);
        e.fl = {e.res == 16'h0, e.err, e.res[15]};
      end
      RED: begin
        s = 0;
        for (int i = 0; i < 2; i++) s = s + sval(32'(a >> (8*i)), 8) + sval(32'(b >> (8*i)), 8);
        e.res = 16'(s);
      end
      PADDSB: begin
        for (int l = 0; l < 4; l++) begin
          la = sval(32'(a >> (4*l)), 4);
          lb = sval(32'(b >> (4*l)), 4);
          s = la + lb;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          e.res[4*l +: 4] = 4'(s);
        end
      end
      default: begin
        if (op == XOR) e.res = a ^ b;
        else if (op == SLL) e.res = 16'(32'(a) << sh);
        else if (op == SRA) e.res = 16'(sa >>> sh);
        else for (int i = 0; i < 16; i++) e.res[i] = a[(i + sh) % 16];
        e.fl[2] = (e.res == 16'h0);
      end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op and wait (bounded) for its transfer, then queue the modelled response
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    last_wait = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    #1;
    while (!in_ready && last_wait < 50) begin
      @(negedge clk); #1;
      last_wait++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready stayed 0 for op %0d", op);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(op, a, b, mflags);
    mflags = e.fl;
    q.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic set_stall(input logic v);
    @(posedge clk); #1 stall_req = v;
    @(negedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    if (q.size() != 0 || out_valid) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, out_valid=%0b", q.size(), out_valid);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  // Consumer backpressure
  always @(negedge clk) begin
    out_ready = stall_req ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: compare every output transfer against the head of the scoreboard
  always begin
    @(negedge clk); #2;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard", out_result);
      end else begin
        mon_e = q.pop_front();
        check("result", 32'(out_result), 32'(mon_e.res));
        check("err", 32'(out_err), 32'(mon_e.err));
        check("flags", 32'(flags), 32'(mon_e.fl));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    stall_req = 1'b0; bp_rand = 1'b0; mflags = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(out_result), 0);
    check("rst_err", 32'(out_err), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed corner vectors
    issue(ADD, 16'h7FFF, 16'h0001);
    issue(SUB, 16'h0005, 16'h0005);
    issue(RED, 16'h0102, 16'h0304);
    issue(PADDSB, 16'h7F18, 16'h0178);
    issue(ROR, 16'h8001, 16'h0001);
    issue(SRA, 16'h8000, 16'h000F);
    issue(SLL, 16'h8000, 16'h0001);
    issue(ADD, 16'h8000, 16'hFFFF);
    issue(SUB, 16'h7FFF, 16'hFFFF);
    issue(ROR, 16'h1234, 16'h0010);
    issue(XOR, 16'hA5A5, 16'hA5A5);
    issue(RED, 16'h8080, 16'hFF7F);
    drain();

    // Full throughput with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      if (i > 0) check("throughput_wait", 32'(last_wait), 0);
    end
    drain();

    // Stall mid-stream: pipe fills, in_ready drops, output held
    set_stall(1'b1);
    issue(ADD, 16'h1000, 16'h0234);
    issue(XOR, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_result", 32'(out_result), 32'(16'h1234));
    end
    set_stall(1'b0);
    issue(SUB, 16'h0001, 16'h0002);
    issue(SLL, 16'h0003, 16'h0004);
    drain();

    // Flush with two ops in flight: the op already in S2 keeps its flag update
    set_stall(1'b1);
    issue(ADD, 16'h7FFF, 16'h0001);
    f_keep = mflags;
    issue(XOR, 16'h0000, 16'h0000);
    @(negedge clk); flush = 1'b1; #1;
    check("flush_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 flush = 1'b0;
    q.delete();
    mflags = f_keep;
    @(negedge clk); #1;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_flags", 32'(flags), 32'(f_keep));
    set_stall(1'b0);
    issue(RED, 16'h0101, 16'h0101);
    issue(SLL, 16'h0001, 16'h0003);
    drain();

    // Randomized traffic under random backpressure
    bp_rand = 1'b1;
    repeat (300) issue(3'($urandom_range(0, 7)), pick(), pick());
    drain();
    bp_rand = 1'b0;

    // Reset mid-stream discards everything in flight
    issue(ADD, 16'h4000, 16'h4000);
    issue(SUB, 16'h0000, 16'h0001);
    issue(XOR, 16'h1111, 16'h2222);
    rst = 1'b1;
    q.delete();
    mflags = 3'b000;
    @(posedge clk);
    @(negedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_result", 32'(out_result), 0);
    check("midrst_err", 32'(out_err), 0);
    check("midrst_flags", 32'(flags), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    issue(SRA, 16'hF000, 16'h0004);
    issue(ADD, 16'h0001, 16'h0001);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
